// File: rtl/frame_update_scheduler.sv
// rtl/frame_update_scheduler.sv - per-frame game update sequencer started at vertical blanking
module frame_update_scheduler #(
    parameter int BLANK_LINE = 480,
    parameter int TIMEOUT    = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic [11:0] pad_btn,
    input  logic        pad_present,
    input  logic [2:0]  task_done,
    output logic [2:0]  task_req,
    output logic [11:0] pad_latched,
    output logic [7:0]  frame_cnt,
    output logic        busy,
    output logic        paused,
    output logic [3:0]  overrun_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_ISSUE, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [11:0]   pad_latched_q, pad_latched_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          paused_q, paused_d;
    logic [3:0]    overrun_q, overrun_d;

    logic          trigger;
    logic          active_start;
    logic [11:0]   pad_now;
    logic          start_press;
    logic [2:0]    task_sel;
    logic          done_cur;
    logic [TW-1:0] tmo_inc;

    always_comb begin
        trigger      = (vpos == 10'(BLANK_LINE)) && (hpos == '0);
        active_start = (vpos == '0) && (hpos == '0);
        pad_now      = pad_present ? pad_btn : '0;
        // Edge-detect start against the previous frame's snapshot, not the live pad.
        start_press  = pad_now[8] & ~pad_latched_q[8];
        task_sel     = 3'b001 << idx_q;
        done_cur     = |(task_done & task_sel);
        tmo_inc      = tmo_q + TW'(1);

        state_d       = state_q;
        idx_d         = idx_q;
        tmo_d         = tmo_q;
        pad_latched_d = pad_latched_q;
        frame_cnt_d   = frame_cnt_q;
        paused_d      = paused_q;
        overrun_d     = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (trigger) state_d = S_LATCH;
            end
            S_LATCH: begin
                pad_latched_d = pad_now;
                frame_cnt_d   = frame_cnt_q + 8'd1;
                paused_d      = paused_q ^ start_press;
                idx_d         = 2'd0;
                state_d       = paused_d ? S_IDLE : S_ISSUE;
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion wins over a same-cycle abort.
                if (done_cur) begin
                    if (idx_q == 2'd2) begin
                        idx_d   = 2'd0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_ISSUE;
                    end
                end else if (active_start || (tmo_inc == TW'(TIMEOUT))) begin
                    idx_d   = 2'd0;
                    state_d = S_IDLE;
                    if (overrun_q != 4'hF) overrun_d = overrun_q + 4'd1;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= 2'd0;
            tmo_q         <= '0;
            pad_latched_q <= '0;
            frame_cnt_q   <= '0;
            paused_q      <= 1'b0;
            overrun_q     <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            tmo_q         <= tmo_d;
            pad_latched_q <= pad_latched_d;
            frame_cnt_q   <= frame_cnt_d;
            paused_q      <= paused_d;
            overrun_q     <= overrun_d;
        end
    end

    assign task_req    = (state_q == S_ISSUE) ? task_sel : 3'b000;
    assign busy        = (state_q != S_IDLE);
    assign pad_latched = pad_latched_q;
    assign frame_cnt   = frame_cnt_q;
    assign paused      = paused_q;
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// tb/tb_frame_update_scheduler.sv - table-driven and directed checks for frame_update_scheduler
module tb_frame_update_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  hpos, vpos;
    logic [11:0] pad_btn;
    logic        pad_present;
    logic [2:0]  task_done;
    logic [2:0]  task_req;
    logic [11:0] pad_latched;
    logic [7:0]  frame_cnt;
    logic        busy, paused;
    logic [3:0]  overrun_cnt;

    always #5 clk = ~clk;

    frame_update_scheduler #(.BLANK_LINE(480), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos),
        .pad_btn(pad_btn), .pad_present(pad_present), .task_done(task_done),
        .task_req(task_req), .pad_latched(pad_latched), .frame_cnt(frame_cnt),
        .busy(busy), .paused(paused), .overrun_cnt(overrun_cnt)
    );

    typedef struct {
        logic [11:0] pad;
        logic        present;
        logic [11:0] exp_lat;
        logic        exp_paused;
        int          exp_nreq;
    } vec_t;

    vec_t tbl[10];
    int   total = 0;
    int   bad   = 0;
    int   fc_model = 0;
    int   nreq, end_cyc;
    int   req_cyc[3];
    int   req_val[3];
    bit   width_ok;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        vpos = 10'd100;
        hpos = 10'd5;
        task_done = 3'b000;
    endtask

    // Trigger one frame and follow it until busy drops; a responder answers each req after 3 cycles.
    task automatic run_frame(input logic [11:0] pad, input logic present, input bit resp,
                             input int wrong_at, input int vs_at, input int trig_at);
        int due = -1;
        int c;
        logic [2:0] due_bit = 3'b000;
        logic [2:0] prev = 3'b000;
        nreq = 0;
        end_cyc = -1;
        width_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_cyc[i] = -1;
            req_val[i] = -1;
        end
        vpos = 10'd480; hpos = 10'd0;
        pad_btn = pad; pad_present = present; task_done = 3'b000;
        tick();
        c = 1;
        fc_model = (fc_model + 1) % 256;
        for (int k = 0; k < 60; k++) begin
            if (c == 2) pad_btn = ~pad;
            if (task_req != 3'b000) begin
                if (nreq < 3) begin
                    req_cyc[nreq] = c;
                    req_val[nreq] = int'(task_req);
                end
                nreq++;
                if (prev != 3'b000) width_ok = 1'b0;
                if (resp) begin
                    due = c + 3;
                    due_bit = task_req;
                end
            end
            prev = task_req;
            task_done = (c == due) ? due_bit : 3'b000;
            if (c == wrong_at) task_done = 3'b110;
            if (c == vs_at) begin
                vpos = 10'd0; hpos = 10'd0;
            end else if (c == trig_at) begin
                vpos = 10'd480; hpos = 10'd0;
            end else begin
                vpos = 10'd481; hpos = 10'd5;
            end
            if (!busy) begin
                end_cyc = c;
                break;
            end
            tick();
            c++;
        end
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        tbl[0] = '{12'h0F0, 1'b1, 12'h0F0, 1'b0, 3};
        tbl[1] = '{12'h0F0, 1'b0, 12'h000, 1'b0, 3};
        tbl[2] = '{12'h100, 1'b1, 12'h100, 1'b1, 0};
        tbl[3] = '{12'h100, 1'b1, 12'h100, 1'b1, 0};
        tbl[4] = '{12'h000, 1'b1, 12'h000, 1'b1, 0};
        tbl[5] = '{12'h100, 1'b1, 12'h100, 1'b0, 3};
        tbl[6] = '{12'h100, 1'b0, 12'h000, 1'b0, 3};
        tbl[7] = '{12'h900, 1'b1, 12'h900, 1'b1, 0};
        tbl[8] = '{12'h100, 1'b0, 12'h000, 1'b1, 0};
        tbl[9] = '{12'h100, 1'b1, 12'h100, 1'b0, 3};

        rst_n = 1'b0;
        pad_btn = 12'hFFF; pad_present = 1'b1;
        idle_inputs();
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_req", task_req, 0);
        check("rst_pad", pad_latched, 0);
        check("rst_fcnt", frame_cnt, 0);
        check("rst_paused", paused, 0);
        check("rst_overrun", overrun_cnt, 0);
        rst_n = 1'b1;
        begin
            int spurious = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (task_req != 3'b000 || busy) spurious++;
            end
            check("no_req_after_reset", spurious, 0);
        end

        // Normal frame timing.
        run_frame(12'h000, 1'b1, 1'b1, -1, -1, -1);
        check("norm_nreq", nreq, 3);
        check("norm_req0_cyc", req_cyc[0], 2);
        check("norm_req1_cyc", req_cyc[1], 6);
        check("norm_req2_cyc", req_cyc[2], 10);
        check("norm_req0_val", req_val[0], 1);
        check("norm_req1_val", req_val[1], 2);
        check("norm_req2_val", req_val[2], 4);
        check("norm_width", int'(width_ok), 1);
        check("norm_end", end_cyc, 14);
        check("norm_fcnt", frame_cnt, 1);

        // Pad snapshot and pause behaviour.
        for (int i = 0; i < 10; i++) begin
            run_frame(tbl[i].pad, tbl[i].present, 1'b1, -1, -1, -1);
            check($sformatf("tbl%0d_lat", i), pad_latched, tbl[i].exp_lat);
            check($sformatf("tbl%0d_paused", i), paused, tbl[i].exp_paused);
            check($sformatf("tbl%0d_nreq", i), nreq, tbl[i].exp_nreq);
            check($sformatf("tbl%0d_end", i), end_cyc, tbl[i].exp_paused ? 2 : 14);
            check($sformatf("tbl%0d_fcnt", i), frame_cnt, fc_model);
        end

        // Start of active video aborts WAIT.
        run_frame(12'h000, 1'b1, 1'b1, -1, 4, -1);
        check("vs_abort_end", end_cyc, 5);
        check("vs_abort_nreq", nreq, 1);
        check("vs_abort_overrun", overrun_cnt, 1);

        // Done in the same cycle as active-video start wins.
        run_frame(12'h000, 1'b1, 1'b1, -1, 5, -1);
        check("prec_nreq", nreq, 3);
        check("prec_end", end_cyc, 14);
        check("prec_overrun", overrun_cnt, 1);

        // Wrong-index done ignored, trigger while busy ignored.
        run_frame(12'h000, 1'b1, 1'b1, 4, -1, 8);
        check("wrong_req1_cyc", req_cyc[1], 6);
        check("wrong_nreq", nreq, 3);
        check("wrong_end", end_cyc, 14);
        check("trig_busy_fcnt", frame_cnt, fc_model);
        check("trig_busy_idle", busy, 0);

        // Timeout and overrun saturation.
        run_frame(12'h000, 1'b1, 1'b0, -1, -1, -1);
        check("tmo_end", end_cyc, 11);
        check("tmo_nreq", nreq, 1);
        check("tmo_overrun", overrun_cnt, 2);
        for (int i = 0; i < 12; i++) run_frame(12'h000, 1'b1, 1'b0, -1, -1, -1);
        check("tmo_overrun_14", overrun_cnt, 14);
        for (int i = 0; i < 7; i++) run_frame(12'h000, 1'b1, 1'b0, -1, -1, -1);
        check("tmo_overrun_sat", overrun_cnt, 15);
        check("tmo_fcnt", frame_cnt, fc_model);

        // frame_cnt wrap.
        while (fc_model != 255) run_frame(12'h000, 1'b1, 1'b1, -1, -1, -1);
        check("fcnt_255", frame_cnt, 255);
        run_frame(12'h000, 1'b1, 1'b1, -1, -1, -1);
        check("fcnt_wrap", frame_cnt, 0);

        // Reset asserted during WAIT.
        pad_btn = 12'h0F0; pad_present = 1'b1;
        vpos = 10'd480; hpos = 10'd0;
        tick();
        idle_inputs();
        tick();
        tick();
        tick();
        check("pre_rst_busy", busy, 1);
        check("pre_rst_pad", pad_latched, 12'h0F0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_req", task_req, 0);
        check("mid_rst_pad", pad_latched, 0);
        check("mid_rst_fcnt", frame_cnt, 0);
        check("mid_rst_paused", paused, 0);
        check("mid_rst_overrun", overrun_cnt, 0);
        rst_n = 1'b1;
        begin
            int spurious = 0;
            for (int i = 0; i < 30; i++) begin
                tick();
                if (task_req != 3'b000 || busy) spurious++;
            end
            check("no_req_after_mid_rst", spurious, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_update_scheduler.md
FRAME_UPDATE_SCHEDULER -- requirements
Module: frame_update_scheduler

Interface
REQ-001 Parameter BLANK_LINE, default 480: vpos value that marks start of vertical blanking.
REQ-002 Parameter TIMEOUT, default 4095: maximum cycles to wait for one task_done.
REQ-003 clk  input  1  system/pixel clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 hpos  input  10  current horizontal pixel position from sync generator.
REQ-006 vpos  input  10  current line from sync generator.
REQ-007 pad_btn  input  12  live gamepad buttons {b,y,select,start,up,down,left,right,a,x,l,r}, bit 11 = b, bit 8 = start.
REQ-008 pad_present  input  1  gamepad detected.
REQ-009 task_done  input  3  per-task completion pulse from update units.
REQ-010 task_req  output  3  one-hot task start pulse: 0 = player input/movement, 1 = projectiles, 2 = collision.
REQ-011 pad_latched  output  12  button snapshot, stable for a whole frame.
REQ-012 frame_cnt  output  8  frames triggered since reset.
REQ-013 busy  output  1  scheduler not IDLE.
REQ-014 paused  output  1  game paused; tasks are skipped.
REQ-015 overrun_cnt  output  4  frames aborted, saturating.

Function
REQ-016 States IDLE, LATCH, ISSUE, WAIT; 2-bit task index idx; busy SHALL be 1 in every state except IDLE.
REQ-017 Trigger = (vpos == BLANK_LINE && hpos == 0); IDLE SHALL go to LATCH at the clock edge where trigger is sampled (cycle 0). Trigger SHALL be ignored in every state except IDLE.
REQ-018 LATCH (cycle 1): pad_latched <= pad_present ? pad_btn : 0; frame_cnt increments, wrapping 255 -> 0.
REQ-019 In LATCH, a start press SHALL toggle paused. A start press is new pad_btn[8] = 1 (gated by pad_present) while the previous pad_latched[8] = 0.
REQ-020 LATCH SHALL go to IDLE if the updated paused value is 1; otherwise it SHALL go to ISSUE with idx = 0.
REQ-021 ISSUE: task_req SHALL be decoded from state, high only at bit idx, for exactly one cycle (cycle 2 for task 0). Next state is WAIT, and the timeout counter clears to 0.
REQ-022 task_req SHALL be 0 in every state except ISSUE.
REQ-023 WAIT: task_done[idx] = 1 SHALL advance to ISSUE with idx + 1, or to IDLE when idx = 2. task_done bits other than idx SHALL be ignored.
REQ-024 WAIT: the timeout counter increments each cycle without done. When it reaches TIMEOUT, the scheduler SHALL abort to IDLE and increment overrun_cnt.
REQ-025 WAIT: sampling vpos == 0 && hpos == 0 (active video starts) before completion SHALL abort to IDLE and increment overrun_cnt.
REQ-026 When task_done[idx] and an abort condition occur in the same cycle, done SHALL take precedence, with no overrun counted.
REQ-027 overrun_cnt SHALL saturate at 15.
REQ-028 pad_latched, paused, frame_cnt SHALL change only in LATCH.

Reset
REQ-029 rst_n = 0 at a clock edge SHALL force IDLE, idx = 0, timeout counter = 0, task_req = 0, pad_latched = 0, frame_cnt = 0, paused = 0, overrun_cnt = 0, busy = 0, in any state including mid-task.
REQ-030 After reset release, no task_req SHALL issue before the next trigger.

Verification
REQ-031 Normal frame: update units answer task_done[idx] 3 cycles after each req -> task_req sequence 001, 010, 100, each 1 cycle wide, first at trigger + 2; busy falls after the third done; frame_cnt = 1.
REQ-032 Pad snapshot: pad_btn = 12'h0F0, present = 1 at LATCH, then pad_btn changes mid-frame -> pad_latched stays 12'h0F0 until the next LATCH. With present = 0 -> pad_latched = 0.
REQ-033 Pause: start held over two frames -> paused = 1 after frame 1 with no task_req, stays 1 on frame 2. Release, then press again -> paused = 0 and tasks resume. frame_cnt increments on all frames.
REQ-034 Timeout/overrun: TIMEOUT = 8, no task_done -> IDLE 8 cycles after WAIT entry, overrun_cnt = 1. Repeat 20 frames -> overrun_cnt = 15. Done at the same cycle as vpos = 0, hpos = 0 -> no increment.
REQ-035 Robustness: a wrong-index task_done is ignored; the trigger is ignored while busy; 256 frames wrap frame_cnt to 0; rst_n low during WAIT -> all outputs reach reset values next cycle.
